// File: rtl/mat_pkg.sv
`default_nettype none
// ============================================================================
// Module : mat_pkg
// Desc   : Shared matrix dimensions, element/row types and LOAD/DRAIN state.
// Rev    : 1.0  initial release
// ============================================================================
package mat_pkg;

  localparam int DIM   = 5;
  localparam int EW    = 8;
  localparam int ROW_W = DIM * EW;
  localparam int IDX_W = $clog2(DIM);

  typedef logic signed [EW-1:0]       elem_t;
  typedef logic [ROW_W-1:0]           row_t;
  typedef logic [DIM-1:0][ROW_W-1:0]  mat_t;
  typedef logic [IDX_W-1:0]           idx_t;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } mat_state_e;

  // Element 0 of a row sits in the most significant byte.
  function automatic elem_t row_elem(input row_t row, input int c);
    return row[ROW_W-1-EW*c -: EW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_col_mux.sv
`default_nettype none
// ============================================================================
// Module : mat_col_mux
// Desc   : Combinational column select; gathers element idx of every row.
// Rev    : 1.0  initial release
// ============================================================================
module mat_col_mux
  import mat_pkg::*;
(
  input  logic [DIM-1:0][ROW_W-1:0] i_rows,
  input  logic [IDX_W-1:0]          i_idx,
  output logic [ROW_W-1:0]          o_col
);

  for (genvar r = 0; r < DIM; r++) begin : g_row
    elem_t w_sel;

    // Out-of-range indices yield zero rather than an undefined slice.
    always_comb begin
      w_sel = '0;
      for (int c = 0; c < DIM; c++) begin
        if (i_idx == IDX_W'(c)) begin
          w_sel = row_elem(i_rows[r], c);
        end
      end
    end

    assign o_col[ROW_W-1-EW*r -: EW] = w_sel;
  end

endmodule
`default_nettype wire

// File: rtl/mat_col_buffer.sv
`default_nettype none
// ============================================================================
// Module : mat_col_buffer
// Desc   : Accepts a DIMxDIM matrix row by row, returns it column by column.
// Rev    : 1.0  initial release
// ============================================================================
module mat_col_buffer
  import mat_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_col,
  output logic             out_last,
  output logic             busy
);

  localparam idx_t c_last_idx = idx_t'(DIM - 1);

  mat_state_e r_state;
  idx_t       r_row_cnt;
  idx_t       r_col_cnt;
  mat_t       r_buf;
  row_t       r_out_col;

  mat_t       w_buf_next;
  row_t       w_col;
  idx_t       w_col_idx;
  logic       w_in_fire;
  logic       w_out_fire;

  assign in_ready   = (r_state == LOAD);
  assign out_valid  = (r_state == DRAIN);
  assign out_col    = r_out_col;
  assign out_last   = out_valid & (r_col_cnt == c_last_idx);
  assign busy       = (r_state == DRAIN) | (r_row_cnt != '0);

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_ready & out_valid;

  // The incoming row is merged before the column select so column 0 can be
  // registered on the same edge that accepts the final row.
  always_comb begin
    w_buf_next = r_buf;
    if (w_in_fire) begin
      w_buf_next[r_row_cnt] = in_row;
    end
  end

  assign w_col_idx = (r_state == LOAD) ? '0 : r_col_cnt + idx_t'(1);

  mat_col_mux u_col_mux (
    .i_rows (w_buf_next),
    .i_idx  (w_col_idx),
    .o_col  (w_col)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
      r_buf     <= '0;
      r_out_col <= '0;
    end else begin
      r_buf <= w_buf_next;
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            if (r_row_cnt == c_last_idx) begin
              r_row_cnt <= '0;
              r_state   <= DRAIN;
              r_out_col <= w_col;
            end else begin
              r_row_cnt <= r_row_cnt + idx_t'(1);
            end
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            // The final column stays on out_col after it is taken.
            if (r_col_cnt == c_last_idx) begin
              r_col_cnt <= '0;
              r_state   <= LOAD;
            end else begin
              r_col_cnt <= r_col_cnt + idx_t'(1);
              r_out_col <= w_col;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_col_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_mat_col_buffer
// Desc   : Self-checking bench for mat_col_buffer against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mat_col_buffer;
  import mat_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_col;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_col_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Column c gathers byte c of every row, row 0 ending up in the top byte.
  function automatic logic [ROW_W-1:0] column_of(input logic [ROW_W-1:0] rows [DIM], input int c);
    logic [ROW_W-1:0] col = '0;
    for (int r = 0; r < DIM; r++) begin
      col = (col << EW) | ((rows[r] >> (EW * (DIM - 1 - c))) & ROW_W'(8'hFF));
    end
    return col;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    return ROW_W'({$urandom(), $urandom()});
  endfunction

  // Reference: rows collect until a matrix is complete, then its columns
  // form a queue; while the queue is non-empty the block is draining.
  logic [ROW_W-1:0] m_rows [DIM];
  logic [ROW_W-1:0] m_q [$];
  logic [ROW_W-1:0] m_hold = '0;
  int               m_cnt  = 0;
  bit               m_fin, m_fout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_q.delete();
      m_hold = '0;
    end else begin
      m_fin  = in_valid && (m_q.size() == 0);
      m_fout = out_ready && (m_q.size() != 0);
      if (m_fout) m_hold = m_q.pop_front();
      if (m_fin) begin
        m_rows[m_cnt] = in_row;
        m_cnt++;
        if (m_cnt == DIM) begin
          for (int c = 0; c < DIM; c++) m_q.push_back(column_of(m_rows, c));
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  ROW_W'(in_ready),  ROW_W'(m_q.size() == 0));
    chk("out_valid", ROW_W'(out_valid), ROW_W'(m_q.size() != 0));
    chk("out_last",  ROW_W'(out_last),  ROW_W'(m_q.size() == 1));
    chk("busy",      ROW_W'(busy),      ROW_W'((m_cnt != 0) || (m_q.size() != 0)));
    chk("out_col",   out_col,           (m_q.size() != 0) ? m_q[0] : m_hold);
  end

  // Present inputs for one edge; returns 2 time units after that edge.
  task automatic step(input logic v, input logic [ROW_W-1:0] row, input logic r);
    in_valid  = v;
    in_row    = row;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [ROW_W-1:0] rows [DIM]);
    for (int i = 0; i < DIM; i++) step(1'b1, rows[i], 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < DIM; i++) step(1'b0, '0, 1'b1);
  endtask

  logic [ROW_W-1:0] basic_rows [DIM] = '{40'h0001020304, 40'h1011121314, 40'h2021222324,
                                         40'h3031323334, 40'h4041424344};
  logic [ROW_W-1:0] basic_cols [DIM] = '{40'h0010203040, 40'h0111213141, 40'h0212223242,
                                         40'h0313233343, 40'h0414243444};
  logic [ROW_W-1:0] sg_rows    [DIM] = '{40'h80FF7F0100, 40'h0, 40'h0, 40'h0, 40'h0};
  logic [ROW_W-1:0] sg_cols    [DIM] = '{40'h8000000000, 40'hFF00000000, 40'h7F00000000,
                                         40'h0100000000, 40'h0000000000};
  logic [ROW_W-1:0] rr [DIM];
  logic [ROW_W-1:0] held;
  int               rises [$];
  logic             prev;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_in_ready",  ROW_W'(in_ready),  ROW_W'(1));
    chk("rst_out_valid", ROW_W'(out_valid), ROW_W'(0));
    chk("rst_out_col",   out_col,           '0);
    chk("rst_busy",      ROW_W'(busy),      ROW_W'(0));
    rst = 1'b0;

    chk("model_pin", column_of(basic_rows, 2), 40'h0212223242);

    // Basic transpose
    for (int i = 0; i < DIM - 1; i++) step(1'b1, basic_rows[i], 1'b1);
    chk("basic_pre_valid", ROW_W'(out_valid), ROW_W'(0));
    step(1'b1, basic_rows[DIM-1], 1'b1);
    chk("basic_latency", ROW_W'(out_valid), ROW_W'(1));
    for (int c = 0; c < DIM; c++) begin
      chk("basic_col",  out_col,           basic_cols[c]);
      chk("basic_last", ROW_W'(out_last),  ROW_W'(c == DIM - 1));
      step(1'b0, '0, 1'b1);
    end
    chk("basic_done_valid", ROW_W'(out_valid), ROW_W'(0));
    chk("basic_done_col",   out_col,           basic_cols[DIM-1]);

    // Signed values pass bit-exactly
    load(sg_rows);
    for (int c = 0; c < DIM; c++) begin
      chk("signed_col", out_col, sg_cols[c]);
      step(1'b0, '0, 1'b1);
    end

    // Backpressure on column 2
    for (int i = 0; i < DIM; i++) rr[i] = rand_row();
    load(rr);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    held = out_col;
    chk("bp_col2", out_col, column_of(rr, 2));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b0);
      chk("bp_hold", out_col, held);
      chk("bp_last", ROW_W'(out_last), ROW_W'(0));
    end
    for (int c = 2; c < DIM; c++) begin
      chk("bp_order", out_col, column_of(rr, c));
      step(1'b0, '0, 1'b1);
    end

    // Rows offered during drain must be ignored
    for (int i = 0; i < DIM; i++) rr[i] = rand_row() & 40'h7F7F7F7F7F;
    load(rr);
    for (int k = 0; k < 2 * DIM; k++) begin
      if (out_valid) chk("drain_in_ready", ROW_W'(in_ready), ROW_W'(0));
      step(1'b1, {ROW_W{1'b1}}, 1'(k % 2));
    end
    chk("drain_done", ROW_W'(out_valid), ROW_W'(0));
    for (int i = 0; i < DIM; i++) rr[i] = rand_row() & 40'h7F7F7F7F7F;
    load(rr);
    chk("drain_next_col0", out_col, column_of(rr, 0));
    drain();

    // Reset in the middle of a load
    for (int i = 0; i < 3; i++) step(1'b1, rand_row(), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",      ROW_W'(busy),      ROW_W'(0));
    chk("mid_rst_in_ready",  ROW_W'(in_ready),  ROW_W'(1));
    chk("mid_rst_out_valid", ROW_W'(out_valid), ROW_W'(0));
    chk("mid_rst_out_col",   out_col,           '0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < DIM; i++) rr[i] = rand_row();
    load(rr);
    for (int c = 0; c < DIM; c++) begin
      chk("mid_rst_col", out_col, column_of(rr, c));
      step(1'b0, '0, 1'b1);
    end

    // Throughput with always-valid source and always-ready sink
    prev = out_valid;
    for (int k = 1; k <= 25; k++) begin
      step(1'b1, rand_row(), 1'b1);
      if (out_valid && !prev) rises.push_back(k);
      prev = out_valid;
    end
    chk("tput_rises", ROW_W'(rises.size() >= 2), ROW_W'(1));
    if (rises.size() >= 2) chk("tput_period", ROW_W'(rises[1] - rises[0]), ROW_W'(10));
    drain();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 149) == 0) rst = 1'b1;
      step(1'($urandom_range(0, 9) < 7), rand_row(), 1'($urandom_range(0, 9) < 7));
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mat_col_buffer.md
# mat_col_buffer

Buffers one 5x5 signed 8-bit matrix delivered row by row and returns it column by column, so each output word is one column of the input matrix, i.e. one row of its transpose. It sits between the matrix register file and the column-consuming datapaths (transpose, multiply) of the coprocessor. Rows and columns both move over valid/ready handshakes, and the block holds a single matrix at a time.

## Interface
- DIM, 5, matrix dimension (rows = columns)
- EW, 8, element width in bits, two's complement
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_row holds a valid row
- in_ready  out  1  block accepts a row this cycle
- in_row  in  DIM*EW (40)  row r; element c at bits [39-8c -: 8], element 0 in the MSBs
- out_valid  out  1  out_col holds a valid column
- out_ready  in  1  consumer accepts out_col this cycle
- out_col  out  DIM*EW (40)  column c; element from row r at bits [39-8r -: 8]
- out_last  out  1  out_col is the final column (c = DIM-1)
- busy  out  1  at least one row has been accepted and the last column is not yet taken

## Operation
- A handshake completes in any cycle where valid and ready are both high at the rising edge.
- The FSM has two states.
  - LOAD: in_ready=1, out_valid=0. Each input handshake writes in_row into buffer row row_cnt, then increments row_cnt. The handshake with row_cnt=DIM-1 moves the FSM to DRAIN, clears row_cnt, and registers column 0 into out_col.
  - DRAIN: in_ready=0, out_valid=1. Each output handshake increments col_cnt and registers column col_cnt+1 into out_col. The handshake with col_cnt=DIM-1 moves the FSM to LOAD and clears col_cnt.
- out_last = out_valid and (col_cnt == DIM-1).
- busy = (state==DRAIN) or (row_cnt != 0).
- Elements are copied bit-exactly. There is no sign extension, saturation, or arithmetic. Signed values such as 8'h80 pass through unchanged.
- in_valid is ignored in DRAIN and out_ready is ignored in LOAD. A row presented during DRAIN is not captured.
- Load and drain never overlap.

## Timing
- Reset values: state=LOAD, row_cnt=0, col_cnt=0, all buffer cells 0, in_ready=1, out_valid=0, out_col=0, out_last=0, busy=0.
- Latency: last row accepted at edge t, then out_valid=1 and out_col=column 0 from t+1.
- Last column taken at edge t, then out_valid=0, out_col unchanged, and in_ready=1 from t+1.
- Throughput with always-valid source and always-ready sink: 2*DIM = 10 cycles per matrix.
- Backpressure: while out_valid=1 and out_ready=0, out_col, out_last and col_cnt hold stable.
- Gaps: in_valid=0 in LOAD holds row_cnt and the buffer.
- Reset mid-operation (any state, any count): all state returns to its reset values immediately. The partial matrix is discarded and the next accepted row is treated as row 0.
- in_ready and out_valid are decoded from the registered state only, with no combinational path from inputs.

## Structure
- Shared package mat_pkg holds:
  - DIM=5, EW=8, ROW_W=DIM*EW
  - element and row typedefs
  - the LOAD/DRAIN state enum, which the other matrix blocks also use
- Sub-module mat_col_mux: purely combinational. It takes the DIMxROW_W buffer plus a column index and produces the packed column. The top-level block instantiates it once, fed with the next-column index.
- Top level contains the FSM, row_cnt/col_cnt, the buffer registers and the out_col register.

## Test plan
- Basic transpose: feed rows 40'h0001020304, 40'h1011121314, 40'h2021222324, 40'h3031323334, 40'h4041424344 back to back. Columns must be 40'h0010203040, 40'h0111213141, …, 40'h0414243444; out_last must be high only on the 5th; out_valid must first rise the cycle after row 5.
- Signed values: a row holding 8'h80, 8'hFF, 8'h7F, 8'h01, 8'h00 must appear unchanged in byte 0 of the five columns. For example, with this as row 0 and all other rows zero, column 0 = 40'h8000000000.
- Backpressure: hold out_ready=0 for 3 cycles while column 2 is presented. out_col must stay stable and col_cnt must not advance; then release and check the order.
- Input during drain: pulse in_valid with 40'hFFFFFFFFFF during DRAIN. in_ready must stay 0, and the next matrix must not contain that value.
- Reset mid-load: accept 3 rows, then assert rst. Check reset values. Then load 5 new rows; the output columns must derive only from the new rows.
- Throughput: stream 2 matrices with always-ready. Column 0 of the second matrix must appear exactly 10 cycles after column 0 of the first.
